rx_frame_ctrl: RTL and testbench

Synchronous UART receive framer. It sits directly upstream of the oversampling bit receiver and turns the raw, asynchronous `rx` line into frame timing: a validated start bit, one strobe per data bit, a stop-bit check and a per-frame done/error pulse. It also samples each data bit at mid-bit and assembles the byte (LSB first). Its `rx_idle` output drives the receiver's idle input directly (low = frame in progress).

---
 rtl/uart_pkg.sv | 6 +
 rtl/sync2.sv | 14 +
 rtl/rx_frame_ctrl.sv | 93 +++++++++
 tb/tb_rx_frame_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing defaults and receive FSM states
package uart_pkg;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous single-bit input
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: UART receive framer producing start/bit/stop timing and the assembled byte
module rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 rx_idle,
  output logic                 bit_strobe,
  output logic [2:0]           bit_index,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_done,
  output logic                 frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [DATA_BITS-1:0] sh, sh_n, data_n;
  logic [2:0] idx_n;
  logic rx_s, rx_s_d, strobe_n, done_n, err_n;
  sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bcnt <= '0;
      sh <= '0;
      rx_s_d <= 1'b1;
      rx_idle <= 1'b1;
      bit_strobe <= 1'b0;
      bit_index <= '0;
      rx_data <= '0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bcnt <= bcnt_n;
      sh <= sh_n;
      rx_s_d <= rx_s;
      rx_idle <= state_n == IDLE;
      bit_strobe <= strobe_n;
      bit_index <= idx_n;
      rx_data <= data_n;
      frame_done <= done_n;
      frame_err <= err_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bcnt_n = bcnt;
    sh_n = sh;
    idx_n = bit_index;
    data_n = rx_data;
    err_n = frame_err;
    strobe_n = 1'b0;
    done_n = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = (~rx_s & rx_s_d) ? START : IDLE;
      end
      START: if (cnt == HALF) begin
        cnt_n = '0;
        bcnt_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n = '0;
        sh_n = {rx_s, sh[DATA_BITS-1:1]};
        strobe_n = 1'b1;
        idx_n = bcnt[2:0];
        bcnt_n = bcnt + 1'b1;
        state_n = (bcnt == BLAST) ? STOP : DATA;
      end
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        done_n = 1'b1;
        data_n = sh;
        err_n = ~rx_s;
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed self-checking bench for rx_frame_ctrl
module tb_rx_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic rx_idle, bit_strobe, frame_done, frame_err;
  logic [2:0] bit_index;
  logic [7:0] rx_data;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fall_cyc = -1;
  int rise_cyc = -1;
  int strobe_cyc[$];
  int idx_log[$];
  int done_cyc[$];
  int done_data[$];
  int done_err[$];
  logic prev_idle = 1'b1;
  logic both_seen = 1'b0;
  rx_frame_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_idle(rx_idle),
    .bit_strobe(bit_strobe),
    .bit_index(bit_index),
    .rx_data(rx_data),
    .frame_done(frame_done),
    .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bit_strobe) begin
      strobe_cyc.push_back(cyc);
      idx_log.push_back(int'(bit_index));
    end
    if (frame_done) begin
      done_cyc.push_back(cyc);
      done_data.push_back(int'(rx_data));
      done_err.push_back(int'(frame_err));
    end
    if (bit_strobe && frame_done) both_seen = 1'b1;
    if (prev_idle && !rx_idle) fall_cyc = cyc;
    if (!prev_idle && rx_idle) rise_cyc = cyc;
    prev_idle = rx_idle;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  function automatic int qget(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int per, input logic stop);
    rx = 1'b0;
    #(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(per);
    end
    rx = stop;
    #(per);
  endtask
  task automatic align();
    @(negedge clk);
    #2;
  endtask
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int bs, bd, gap;
    logic found;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_rx_idle", int'(rx_idle), 1);
    chk("rst_bit_strobe", int'(bit_strobe), 0);
    chk("rst_bit_index", int'(bit_index), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    rst = 1'b0;
    settle(5);
    chk("idle_after_rst", int'(rx_idle), 1);
    bs = strobe_cyc.size();
    bd = done_cyc.size();
    align();
    send(8'hA5, 160, 1'b1);
    settle(20);
    chk("a5_strobes", strobe_cyc.size() - bs, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("a5_idx%0d", k), qget(idx_log, bs + k), k);
    chk("a5_strobe0_ofs", qget(strobe_cyc, bs) - fall_cyc, 24);
    chk("a5_strobe7_ofs", qget(strobe_cyc, bs + 7) - fall_cyc, 136);
    chk("a5_dones", done_cyc.size() - bd, 1);
    chk("a5_done_ofs", qget(done_cyc, bd) - fall_cyc, 152);
    chk("a5_idle_rise", rise_cyc, qget(done_cyc, bd));
    chk("a5_data", qget(done_data, bd), 8'hA5);
    chk("a5_err", qget(done_err, bd), 0);
    chk("a5_data_held", int'(rx_data), 8'hA5);
    bs = strobe_cyc.size();
    bd = done_cyc.size();
    align();
    rx = 1'b0;
    #50;
    rx = 1'b1;
    settle(30);
    chk("glitch_strobes", strobe_cyc.size() - bs, 0);
    chk("glitch_dones", done_cyc.size() - bd, 0);
    chk("glitch_idle_ofs", rise_cyc - fall_cyc, 8);
    chk("glitch_idle", int'(rx_idle), 1);
    bs = strobe_cyc.size();
    bd = done_cyc.size();
    align();
    send(8'h3C, 160, 1'b0);
    #(40 * 160);
    settle(2);
    chk("brk_dones", done_cyc.size() - bd, 1);
    chk("brk_data", qget(done_data, bd), 8'h3C);
    chk("brk_err", qget(done_err, bd), 1);
    chk("brk_strobes", strobe_cyc.size() - bs, 8);
    chk("brk_idle", int'(rx_idle), 1);
    chk("brk_err_held", int'(frame_err), 1);
    rx = 1'b1;
    #(2 * 160);
    align();
    send(8'h5A, 160, 1'b1);
    settle(20);
    chk("brk_next_dones", done_cyc.size() - bd, 2);
    chk("brk_next_data", qget(done_data, bd + 1), 8'h5A);
    chk("brk_next_err", qget(done_err, bd + 1), 0);
    bd = done_cyc.size();
    align();
    send(8'h00, 160, 1'b1);
    send(8'hFF, 160, 1'b1);
    settle(20);
    chk("b2b_dones", done_cyc.size() - bd, 2);
    gap = qget(done_cyc, bd + 1) - qget(done_cyc, bd);
    chk("b2b_gap_in_range", int'(gap >= 158 && gap <= 162), 1);
    chk("b2b_data0", qget(done_data, bd), 8'h00);
    chk("b2b_err0", qget(done_err, bd), 0);
    chk("b2b_data1", qget(done_data, bd + 1), 8'hFF);
    chk("b2b_err1", qget(done_err, bd + 1), 0);
    bs = strobe_cyc.size();
    bd = done_cyc.size();
    found = 1'b0;
    align();
    fork
      send(8'hF9, 160, 1'b1);
    join_none
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      #1;
      found = bit_strobe && bit_index == 3'd3;
    end
    chk("mid_strobe3_found", int'(found), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_idle", int'(rx_idle), 1);
    chk("mid_rst_data", int'(rx_data), 0);
    chk("mid_rst_err", int'(frame_err), 0);
    chk("mid_rst_strobe", int'(bit_strobe), 0);
    rst = 1'b0;
    wait fork;
    settle(40);
    chk("mid_rst_no_done", done_cyc.size() - bd, 0);
    chk("mid_rst_strobes", strobe_cyc.size() - bs, 4);
    align();
    send(8'h42, 160, 1'b1);
    settle(20);
    chk("mid_rst_fresh_dones", done_cyc.size() - bd, 1);
    chk("mid_rst_fresh_data", qget(done_data, bd), 8'h42);
    bd = done_cyc.size();
    align();
    send(8'h55, 155, 1'b1);
    settle(30);
    chk("fast_dones", done_cyc.size() - bd, 1);
    chk("fast_data", qget(done_data, bd), 8'h55);
    chk("fast_err", qget(done_err, bd), 0);
    bd = done_cyc.size();
    align();
    send(8'h55, 165, 1'b1);
    settle(30);
    chk("slow_dones", done_cyc.size() - bd, 1);
    chk("slow_data", qget(done_data, bd), 8'h55);
    chk("slow_err", qget(done_err, bd), 0);
    chk("strobe_done_exclusive", int'(both_seen), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
